// File: rtl/crc_tx_arbiter.sv
// ---------------------------------------------------------------------------
// crc_tx_arbiter
//   Shares one CRC transmitter among NREQ requesters. A round-robin arbiter
//   picks one pending request, launches its 16-bit message, waits for the
//   32-bit codeword and returns it to the owner. A watchdog aborts the
//   transaction if the codeword does not arrive in time.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   req          per-requester request level, held until that requester's ack
//   reqData      per-requester 16-bit messages, requester i at [16i+15:16i]
//   reqAck       one-hot one-cycle pulse, transaction ended (codeword or abort)
//   txDataIn     message to the transmitter (stable for the whole transaction)
//   txDataValid  one-cycle launch strobe to the transmitter
//   txBusy       transmitter busy, blocks new launches
//   txCW         codeword from the transmitter {data, crc16}
//   txCWValid    codeword valid, only honoured while waiting
//   cwOut        registered codeword for the owner
//   cwValid      one-cycle pulse qualifying cwOut / cwOwner
//   cwOwner      index of the requester owning cwOut or the abort
//   timeoutErr   one-cycle pulse, transaction aborted by the watchdog
// ---------------------------------------------------------------------------
module crc_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [16*NREQ-1:0]        reqData,
  output logic [NREQ-1:0]           reqAck,
  output logic [15:0]               txDataIn,
  output logic                      txDataValid,
  input  logic                      txBusy,
  input  logic [31:0]               txCW,
  input  logic                      txCWValid,
  output logic [31:0]               cwOut,
  output logic                      cwValid,
  output logic [$clog2(NREQ)-1:0]   cwOwner,
  output logic                      timeoutErr
);

  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [IDW-1:0]   owner_reg;
  logic [IDW-1:0]   last_grant_reg;
  logic [15:0]      data_reg;
  logic [31:0]      cw_reg;
  logic [WDW-1:0]   wd_reg;
  logic             abort_reg;

  logic [15:0]      req_words [NREQ];
  logic             grant_valid;
  logic [IDW-1:0]   grant_idx;
  logic             launch_go;
  logic             wd_expire;
  logic             ack_en;

  // Unpack the flat message bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign req_words[gi] = reqData[16*gi +: 16];
  end

  // Requester index reached by stepping 'offset' places past 'base', wrapping
  // at NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int offset);
    rr_index = IDW'((int'(base) + offset) % NREQ);
  endfunction

  // Round-robin search: the requester just served is looked at last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_valid && req[rr_index(last_grant_reg, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_index(last_grant_reg, k);
      end
    end
  end

  // The cycle that carries an abort ack does not arbitrate, so a requester
  // still holding req while it sees its ack cannot be relaunched by mistake.
  assign launch_go = (state_reg == IDLE) && grant_valid && !txBusy && !abort_reg;

  // True on the edge where the watchdog would reach TIMEOUT-1; a codeword
  // arriving in the same cycle takes priority over the abort.
  assign wd_expire = (state_reg == WAIT) && !txCWValid &&
                     ((wd_reg + 1'b1) == WDW'(TIMEOUT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch_go) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT: begin
        if (txCWValid)      state_next = DELIVER;
        else if (wd_expire) state_next = IDLE;
      end
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (decoded from registered state) ----------
  always_comb begin
    txDataValid = 1'b0;
    cwValid     = 1'b0;
    timeoutErr  = 1'b0;
    ack_en      = 1'b0;
    case (state_reg)
      LAUNCH:  txDataValid = 1'b1;
      DELIVER: begin
        cwValid = 1'b1;
        ack_en  = 1'b1;
      end
      default: ;
    endcase
    if (abort_reg) begin
      timeoutErr = 1'b1;
      ack_en     = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
    assign reqAck[gi] = ack_en && (owner_reg == IDW'(gi));
  end

  assign txDataIn = data_reg;
  assign cwOut    = cw_reg;
  assign cwOwner  = owner_reg;

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg      <= '0;
      last_grant_reg <= IDW'(NREQ - 1);
      data_reg       <= '0;
      cw_reg         <= '0;
      wd_reg         <= '0;
      abort_reg      <= 1'b0;
    end else begin
      abort_reg <= wd_expire;
      case (state_reg)
        IDLE: begin
          // Winner data is captured once, so later reqData changes cannot
          // reach the transmitter mid-transaction.
          if (launch_go) begin
            owner_reg <= grant_idx;
            data_reg  <= req_words[grant_idx];
          end
        end
        LAUNCH: wd_reg <= '0;
        WAIT: begin
          wd_reg <= wd_reg + 1'b1;
          if (txCWValid) begin
            cw_reg <= txCW;
          end else if (wd_expire) begin
            // An aborted owner also goes to the back of the queue.
            last_grant_reg <= owner_reg;
          end
        end
        DELIVER: last_grant_reg <= owner_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_crc_tx_arbiter
//   Directed bench for crc_tx_arbiter (NREQ=4, TIMEOUT=64). The transmitter
//   is modelled inline: the bench raises txCWValid a chosen number of cycles
//   after the launch cycle with codeword {message, 16'h1234}.
// ---------------------------------------------------------------------------
module tb_crc_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [63:0]  reqData;
  logic [3:0]   reqAck;
  logic [15:0]  txDataIn;
  logic         txDataValid;
  logic         txBusy;
  logic [31:0]  txCW;
  logic         txCWValid;
  logic [31:0]  cwOut;
  logic         cwValid;
  logic [1:0]   cwOwner;
  logic         timeoutErr;

  int n_cmp;
  int n_bad;

  crc_tx_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .reqData     (reqData),
    .reqAck      (reqAck),
    .txDataIn    (txDataIn),
    .txDataValid (txDataValid),
    .txBusy      (txBusy),
    .txCW        (txCW),
    .txCWValid   (txCWValid),
    .cwOut       (cwOut),
    .cwValid     (cwValid),
    .cwOwner     (cwOwner),
    .timeoutErr  (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] v);
    reqData[16*i +: 16] = v;
  endtask

  // One transaction from request to ack. cw_delay > 0: codeword driven in
  // cycle launch+cw_delay, so the ack lands at launch+cw_delay+1; otherwise
  // the codeword never comes and the abort lands at launch+TIMEOUT.
  task automatic run_txn(input string tag, input int owner, input logic [15:0] data,
                         input int cw_delay, input int scramble_at, input int exp_lat);
    int n;
    int last;
    int bad_quiet;
    int bad_hold;
    n = 0;
    while (txDataValid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_txdata"}, txDataIn, data);
    last      = (cw_delay > 0) ? cw_delay + 1 : TIMEOUT;
    bad_quiet = 0;
    bad_hold  = 0;
    for (int c = 1; c < last; c++) begin
      step();
      if (txDataValid !== 1'b0 || cwValid !== 1'b0 || timeoutErr !== 1'b0 || reqAck !== 4'b0)
        bad_quiet++;
      if (txDataIn !== data) bad_hold++;
      if (c == scramble_at) reqData[16*owner +: 16] = ~data;
      if (c == cw_delay) begin
        txCWValid = 1'b1;
        txCW      = {data, 16'h1234};
      end
    end
    step();
    txCWValid = 1'b0;
    txCW      = '0;
    check_val({tag, "_quiet"}, bad_quiet, 0);
    check_val({tag, "_hold"}, bad_hold, 0);
    check_val({tag, "_cwvalid"}, cwValid, (cw_delay > 0));
    check_val({tag, "_tmoerr"}, timeoutErr, (cw_delay <= 0));
    check_val({tag, "_ack"}, reqAck, (1 << owner));
    check_val({tag, "_owner"}, cwOwner, owner);
    if (cw_delay > 0) check_val({tag, "_cwout"}, cwOut, {data, 16'h1234});
    req[owner] = 1'b0;
  endtask

  initial begin
    int bad;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req       = '0;
    reqData   = '0;
    txBusy    = 1'b0;
    txCW      = '0;
    txCWValid = 1'b0;
    repeat (3) step();

    // Reset values
    check_val("rst_reqAck", reqAck, 0);
    check_val("rst_txDataValid", txDataValid, 0);
    check_val("rst_txDataIn", txDataIn, 0);
    check_val("rst_cwOut", cwOut, 0);
    check_val("rst_cwValid", cwValid, 0);
    check_val("rst_cwOwner", cwOwner, 0);
    check_val("rst_timeoutErr", timeoutErr, 0);

    // Round robin with all four requesting: order 0,1,2,3,0
    set_word(0, 16'hC0DE);
    set_word(1, 16'hBEEF);
    set_word(2, 16'h1357);
    set_word(3, 16'h2468);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("rr%0d", i), i % 4, reqData[16*(i%4) +: 16], 35, 0, (i == 0) ? 1 : 2);
      req = 4'b1111;
    end
    req = 4'b0000;
    step();
    check_val("rr_pulse_end_ack", reqAck, 0);
    check_val("rr_pulse_end_cwv", cwValid, 0);

    // Codeword outside WAIT is ignored
    txCWValid = 1'b1;
    txCW      = 32'hDEADBEEF;
    step();
    txCWValid = 1'b0;
    txCW      = '0;
    check_val("idle_cw_cwValid", cwValid, 0);
    check_val("idle_cw_cwOut", cwOut, {16'hC0DE, 16'h1234});

    // Single request, message changed by the requester mid-wait
    set_word(0, 16'hA5A5);
    req = 4'b0001;
    run_txn("single", 0, 16'hA5A5, 35, 10, 1);
    set_word(0, 16'hA5A5);

    // Timeout on requester 1, which keeps requesting; 2 must be served next
    req = 4'b0110;
    run_txn("tmo", 1, 16'hBEEF, -1, 0, 2);
    req = 4'b0110;
    run_txn("tmo_next", 2, 16'h1357, 35, 0, 2);
    req = 4'b0001;

    // Codeword on the final watchdog cycle wins over the abort
    run_txn("edge", 0, 16'hA5A5, TIMEOUT - 1, 0, 2);

    // Reset during WAIT abandons the transaction
    req = 4'b0001;
    step();
    step();
    check_val("rstw_launch", txDataValid, 1);
    repeat (10) step();
    rst = 1'b1;
    step();
    check_val("rstw_reqAck", reqAck, 0);
    check_val("rstw_txDataValid", txDataValid, 0);
    check_val("rstw_txDataIn", txDataIn, 0);
    check_val("rstw_cwOut", cwOut, 0);
    check_val("rstw_cwValid", cwValid, 0);
    check_val("rstw_cwOwner", cwOwner, 0);
    check_val("rstw_timeoutErr", timeoutErr, 0);
    rst = 1'b0;
    req = 4'b0011;
    run_txn("post_rst", 0, 16'hA5A5, 35, 0, 1);

    // Busy gating: requester 1 pending, no launch while txBusy
    txBusy = 1'b1;
    bad    = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (txDataValid !== 1'b0) bad++;
    end
    check_val("busy_hold", bad, 0);
    txBusy = 1'b0;
    run_txn("busy", 1, 16'hBEEF, 35, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
